// File: rtl/biriscv_fetch_queue.sv
// Instruction queue between fetch and decode: trims fetch packets into
// per-instruction entries and issues them in program order.
module biriscv_fetch_queue #(
    parameter int FETCH_LANES = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int DEPTH_W     = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     fetch_in_valid_i,
    output logic                     fetch_in_accept_o,
    input  logic [32*FETCH_LANES-1:0] fetch_in_instr_i,
    input  logic [31:0]              fetch_in_pc_i,
    input  logic [FETCH_LANES-1:0]   fetch_in_pred_branch_i,
    input  logic                     fetch_in_fault_fetch_i,
    input  logic                     fetch_in_fault_page_i,
    output logic [ISSUE_WIDTH-1:0]   out_valid_o,
    input  logic [ISSUE_WIDTH-1:0]   out_accept_i,
    output logic [32*ISSUE_WIDTH-1:0] out_instr_o,
    output logic [32*ISSUE_WIDTH-1:0] out_pc_o,
    output logic [ISSUE_WIDTH-1:0]   out_fault_fetch_o,
    output logic [ISSUE_WIDTH-1:0]   out_fault_page_o,
    output logic [ISSUE_WIDTH-1:0]   out_pred_taken_o,
    output logic [DEPTH_W:0]         level_o
);

    localparam int LANE_W = (FETCH_LANES > 1) ? $clog2(FETCH_LANES) : 1;
    localparam int CNT_W  = DEPTH_W + 1;

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t LANES_C = cnt_t'(FETCH_LANES);

    logic [31:0]        instr_q [DEPTH];
    logic [31:0]        pc_q    [DEPTH];
    logic [DEPTH-1:0]   ff_q;
    logic [DEPTH-1:0]   fp_q;
    logic [DEPTH-1:0]   pt_q;

    logic [DEPTH_W-1:0] head_q, head_d;
    logic [DEPTH_W-1:0] tail_q, tail_d;
    cnt_t               count_q, count_d;

    logic [LANE_W-1:0]  start_w;
    logic [LANE_W-1:0]  end_w;
    logic               found_w;
    logic               fault_w;
    logic               push_en;
    cnt_t               push_cnt;
    cnt_t               pop_cnt;
    logic               run_w;

    logic [FETCH_LANES-1:0] wr_en;
    logic [DEPTH_W-1:0]     wr_idx [FETCH_LANES];
    logic [DEPTH_W-1:0]     rd_idx [ISSUE_WIDTH];

    // Free space is judged on the registered count only; pops are not credited
    assign fetch_in_accept_o = rst_ni & ~flush_i &
                               ((DEPTH_C - count_q) >= LANES_C);

    assign start_w = (FETCH_LANES == 1) ? '0 : fetch_in_pc_i[LANE_W+1:2];
    assign fault_w = fetch_in_fault_fetch_i | fetch_in_fault_page_i;
    assign push_en = fetch_in_valid_i & fetch_in_accept_o;
    assign level_o = count_q;

    always_comb begin
        end_w   = LANE_W'(FETCH_LANES - 1);
        found_w = 1'b0;
        for (int k = 0; k < FETCH_LANES; k++) begin
            if (!found_w && (LANE_W'(k) >= start_w) &&
                fetch_in_pred_branch_i[k]) begin
                end_w   = LANE_W'(k);
                found_w = 1'b1;
            end
        end
    end

    always_comb begin
        push_cnt = '0;
        if (push_en) begin
            if (fault_w) push_cnt = cnt_t'(1);
            else         push_cnt = cnt_t'(end_w - start_w) + cnt_t'(1);
        end
    end

    always_comb begin
        for (int k = 0; k < FETCH_LANES; k++) begin
            wr_en[k]  = push_en & ~fault_w &
                        (LANE_W'(k) >= start_w) & (LANE_W'(k) <= end_w);
            wr_idx[k] = tail_q + DEPTH_W'(LANE_W'(k) - start_w);
        end
    end

    always_comb begin
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            rd_idx[j]                = head_q + DEPTH_W'(j);
            out_valid_o[j]           = cnt_t'(j) < count_q;
            out_instr_o[32*j +: 32]  = instr_q[rd_idx[j]];
            out_pc_o[32*j +: 32]     = pc_q[rd_idx[j]];
            out_fault_fetch_o[j]     = ff_q[rd_idx[j]];
            out_fault_page_o[j]      = fp_q[rd_idx[j]];
            out_pred_taken_o[j]      = pt_q[rd_idx[j]];
        end
    end

    // Only an unbroken run of accepts from lane 0 retires entries
    always_comb begin
        pop_cnt = '0;
        run_w   = 1'b1;
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            if (run_w && out_valid_o[j] && out_accept_i[j])
                pop_cnt = pop_cnt + cnt_t'(1);
            else
                run_w = 1'b0;
        end
        if (flush_i) pop_cnt = '0;
    end

    always_comb begin
        head_d  = head_q + pop_cnt[DEPTH_W-1:0];
        tail_d  = tail_q + push_cnt[DEPTH_W-1:0];
        count_d = count_q + push_cnt - pop_cnt;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
            ff_q <= '0;
            fp_q <= '0;
            pt_q <= '0;
        end else if (push_en) begin
            if (fault_w) begin
                instr_q[tail_q] <= '0;
                pc_q[tail_q]    <= fetch_in_pc_i;
                ff_q[tail_q]    <= fetch_in_fault_fetch_i;
                fp_q[tail_q]    <= fetch_in_fault_page_i;
                pt_q[tail_q]    <= 1'b0;
            end else begin
                for (int k = 0; k < FETCH_LANES; k++) begin
                    if (wr_en[k]) begin
                        instr_q[wr_idx[k]] <= fetch_in_instr_i[32*k +: 32];
                        pc_q[wr_idx[k]]    <= {fetch_in_pc_i[31:LANE_W+2],
                                               LANE_W'(k), 2'b00};
                        ff_q[wr_idx[k]]    <= 1'b0;
                        fp_q[wr_idx[k]]    <= 1'b0;
                        pt_q[wr_idx[k]]    <= (LANE_W'(k) == end_w) &
                                              fetch_in_pred_branch_i[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Bench for biriscv_fetch_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_biriscv_fetch_queue;

    localparam int FL = 2;
    localparam int IW = 2;
    localparam int D  = 8;
    localparam int DW = 3;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ff;
        logic        fp;
        logic        pt;
    } ent_t;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_accept;
    logic [32*FL-1:0]  in_instr;
    logic [31:0]       in_pc;
    logic [FL-1:0]     in_pred;
    logic              in_ff;
    logic              in_fp;
    logic [IW-1:0]     o_valid;
    logic [IW-1:0]     o_accept;
    logic [32*IW-1:0]  o_instr;
    logic [32*IW-1:0]  o_pc;
    logic [IW-1:0]     o_ff;
    logic [IW-1:0]     o_fp;
    logic [IW-1:0]     o_pt;
    logic [DW:0]       level;

    ent_t model_q[$];
    int   n_vec;
    int   n_err;

    biriscv_fetch_queue #(
        .FETCH_LANES(FL), .ISSUE_WIDTH(IW), .DEPTH(D), .DEPTH_W(DW)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .flush_i               (flush),
        .fetch_in_valid_i      (in_valid),
        .fetch_in_accept_o     (in_accept),
        .fetch_in_instr_i      (in_instr),
        .fetch_in_pc_i         (in_pc),
        .fetch_in_pred_branch_i(in_pred),
        .fetch_in_fault_fetch_i(in_ff),
        .fetch_in_fault_page_i (in_fp),
        .out_valid_o           (o_valid),
        .out_accept_i          (o_accept),
        .out_instr_o           (o_instr),
        .out_pc_o              (o_pc),
        .out_fault_fetch_o     (o_ff),
        .out_fault_page_o      (o_fp),
        .out_pred_taken_o      (o_pt),
        .level_o               (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Drive one cycle, compare outputs with the model, then advance the model
    task automatic step(input logic v, input logic [63:0] ins,
                        input logic [31:0] pc, input logic [1:0] pred,
                        input logic ff, input logic fp,
                        input logic [1:0] acc, input logic fl);
        logic        exp_acc;
        logic [1:0]  ev;
        int          s, e, n, sz;
        bit          run;
        ent_t        en;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pc = pc; in_pred = pred;
        in_ff = ff; in_fp = fp; o_accept = acc; flush = fl;
        #1;
        sz      = model_q.size();
        exp_acc = !fl && ((D - sz) >= FL);
        check("accept", 32'(in_accept), 32'(exp_acc));
        check("level", 32'(level), 32'(sz));
        for (int j = 0; j < IW; j++) ev[j] = (j < sz);
        check("valid", 32'(o_valid), 32'(ev));
        for (int j = 0; j < IW; j++) begin
            if (j < sz) begin
                check($sformatf("instr%0d", j), o_instr[32*j +: 32],
                      model_q[j].instr);
                check($sformatf("pc%0d", j), o_pc[32*j +: 32],
                      model_q[j].pc);
                check($sformatf("flags%0d", j),
                      {29'd0, o_ff[j], o_fp[j], o_pt[j]},
                      {29'd0, model_q[j].ff, model_q[j].fp, model_q[j].pt});
            end
        end
        if (fl) begin
            model_q.delete();
        end else begin
            n = 0; run = 1;
            for (int j = 0; j < IW; j++) begin
                if (run && j < sz && acc[j]) n++;
                else run = 0;
            end
            repeat (n) void'(model_q.pop_front());
            if (v && exp_acc) begin
                if (ff || fp) begin
                    en.instr = 0; en.pc = pc; en.ff = ff; en.fp = fp;
                    en.pt = 0;
                    model_q.push_back(en);
                end else begin
                    s = (pc / 4) % FL;
                    e = FL - 1;
                    for (int k = FL - 1; k >= s; k--) if (pred[k]) e = k;
                    for (int k = s; k <= e; k++) begin
                        en.instr = ins[32*k +: 32];
                        en.pc    = (pc & ~32'(FL*4 - 1)) | 32'(k*4);
                        en.ff    = 0; en.fp = 0;
                        en.pt    = (k == e) && pred[k];
                        model_q.push_back(en);
                    end
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic [1:0] acc);
        step(0, 64'd0, 32'd0, 2'b00, 0, 0, acc, 0);
    endtask

    task automatic do_flush();
        step(0, 64'd0, 32'd0, 2'b00, 0, 0, 2'b00, 1);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 0; flush = 0; in_valid = 0; in_instr = '0; in_pc = '0;
        in_pred = '0; in_ff = 0; in_fp = 0; o_accept = '0;
        #1;
        check("rst_accept", 32'(in_accept), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        @(negedge clk);
        rst_n = 1;

        // aligned packet
        step(1, {32'h00200093, 32'h00100013}, 32'h1000, 2'b00, 0, 0, 2'b00, 0);
        #1;
        check("tp1_level", 32'(level), 32'd2);
        check("tp1_pc0", o_pc[31:0], 32'h1000);
        check("tp1_in0", o_instr[31:0], 32'h00100013);
        check("tp1_pc1", o_pc[63:32], 32'h1004);
        check("tp1_in1", o_instr[63:32], 32'h00200093);
        idle(2'b00);

        // misaligned start, lane-0 prediction ignored
        do_flush();
        step(1, {32'hAAAA0001, 32'hBBBB0002}, 32'h1004, 2'b01, 0, 0, 2'b00, 0);
        #1;
        check("tp2_level", 32'(level), 32'd1);
        check("tp2_pc", o_pc[31:0], 32'h1004);
        check("tp2_instr", o_instr[31:0], 32'hAAAA0001);
        check("tp2_pt", 32'(o_pt[0]), 32'd0);

        // predicted-taken lane 0 trims the packet
        do_flush();
        step(1, {32'hCCCC0003, 32'hDDDD0004}, 32'h2000, 2'b01, 0, 0, 2'b00, 0);
        #1;
        check("tp3_level", 32'(level), 32'd1);
        check("tp3_pt", 32'(o_pt[0]), 32'd1);
        check("tp3_instr", o_instr[31:0], 32'hDDDD0004);

        // faulted packet
        do_flush();
        step(1, {32'h11111111, 32'h22222222}, 32'h3004, 2'b00, 0, 1, 2'b00, 0);
        #1;
        check("tp4_instr", o_instr[31:0], 32'd0);
        check("tp4_pc", o_pc[31:0], 32'h3004);
        check("tp4_fp", 32'(o_fp[0]), 32'd1);
        check("tp4_ff", 32'(o_ff[0]), 32'd0);

        // fill, partial accept, pop, wrap
        do_flush();
        for (int i = 0; i < 4; i++)
            step(1, {32'(i*2+1), 32'(i*2)}, 32'h4000 + 32'(i*8), 2'b00, 0, 0,
                 2'b00, 0);
        step(1, 64'h5, 32'h5000, 2'b00, 0, 0, 2'b10, 0);
        step(1, 64'h6, 32'h5000, 2'b00, 0, 0, 2'b11, 0);
        for (int i = 0; i < 8; i++)
            step(1, {32'(i+100), 32'(i+200)}, 32'h6000 + 32'(i*8), 2'b00, 0, 0,
                 2'b11, 0);
        for (int i = 0; i < 6; i++) idle(2'b11);

        // flush with valid input at level 5
        do_flush();
        step(1, 64'h1, 32'h7000, 2'b00, 0, 0, 2'b00, 0);
        step(1, 64'h2, 32'h7008, 2'b00, 0, 0, 2'b00, 0);
        step(1, 64'h3, 32'h7014, 2'b00, 0, 0, 2'b00, 0);
        step(1, 64'h4, 32'h7018, 2'b00, 0, 0, 2'b00, 1);
        #1;
        check("flush_level", 32'(level), 32'd0);

        // asynchronous reset at level 3
        step(1, 64'h7, 32'h8000, 2'b00, 0, 0, 2'b00, 0);
        step(1, 64'h8, 32'h8004, 2'b00, 0, 0, 2'b00, 0);
        @(negedge clk);
        in_valid = 0; flush = 0; o_accept = '0;
        #1;
        check("pre_rst_level", 32'(level), 32'd3);
        #1;
        rst_n = 0;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_accept", 32'(in_accept), 32'd0);
        model_q.delete();
        @(negedge clk);
        rst_n = 1;

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 7,
                 {$urandom, $urandom},
                 $urandom & 32'hFFFF_FFFC,
                 2'($urandom),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0,
                 2'($urandom),
                 $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
